tlm_frame_arbiter: RTL and testbench

//  Shares one telemetry RAM write port between NUM_SRC serial packet receivers
//  (GPS time/state-vector receiver and siblings). Each receiver emits a write

---
 rtl/tlm_frame_arbiter_pkg.sv | 23 ++
 rtl/tlm_frame_arbiter_if.sv | 38 +++
 rtl/tlm_frame_arbiter_rr_arbiter.sv | 31 +++
 rtl/tlm_frame_arbiter.sv | 142 ++++++++++++++
 tb/tb_tlm_frame_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tlm_frame_arbiter_pkg.sv
// Shared widths, frame geometry, bank encoding and write payload type for the
// telemetry frame arbiter.
package tlm_arb_pkg;

    localparam int unsigned TLM_ADDR_W      = 5;
    localparam int unsigned TLM_DATA_W      = 8;
    localparam int unsigned FRAME_LEN       = 32;
    localparam int unsigned LAST_PARAM_ADDR = FRAME_LEN - 1;

    localparam logic BANK_0 = 1'b0;
    localparam logic BANK_1 = 1'b1;

    typedef struct packed {
        logic [TLM_ADDR_W-1:0] addr;
        logic [TLM_DATA_W-1:0] data;
    } tlm_wr_t;

    // Source index width; a single source still needs one bit of index.
    function automatic int unsigned src_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tlm_frame_arbiter_if.sv
// Receiver/reader side bundle of the telemetry frame arbiter: per-source
// strobes and params in, RAM write port and frame status out.
interface tlm_arb_if
    import tlm_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2
) ();

    localparam int unsigned SRC_W  = src_idx_w(NUM_SRC);
    localparam int unsigned RAM_AW = SRC_W + 1 + TLM_ADDR_W;

    logic [NUM_SRC-1:0]            src_wclk;
    logic [TLM_ADDR_W*NUM_SRC-1:0] src_waddr;
    logic [TLM_DATA_W*NUM_SRC-1:0] src_byte;
    logic [NUM_SRC-1:0]            frame_ack;
    logic                          err_clr;

    logic                          ram_we;
    logic [RAM_AW-1:0]             ram_waddr;
    logic [TLM_DATA_W-1:0]         ram_wdata;
    logic [NUM_SRC-1:0]            frame_ready;
    logic [NUM_SRC-1:0]            ready_bank;
    logic [NUM_SRC-1:0]            ovf_err;
    logic [NUM_SRC-1:0]            overrun_err;

    modport master (
        output src_wclk, src_waddr, src_byte, frame_ack, err_clr,
        input  ram_we, ram_waddr, ram_wdata, frame_ready, ready_bank,
               ovf_err, overrun_err
    );

    modport slave (
        input  src_wclk, src_waddr, src_byte, frame_ack, err_clr,
        output ram_we, ram_waddr, ram_wdata, frame_ready, ready_bank,
               ovf_err, overrun_err
    );

endinterface

// File: rtl/tlm_frame_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts one past ptr and wraps, so
// the most recently granted source has lowest priority.
module rr_arbiter #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned SRC_W   = 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt_c,
    output logic [SRC_W-1:0]   gnt_idx_c,
    output logic               gnt_vld_c
);

    logic [SRC_W-1:0] cand;

    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        gnt_vld_c = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = SRC_W'((32'(ptr) + k) % NUM_SRC);
            if (!gnt_vld_c && req[cand]) begin
                gnt_vld_c   = 1'b1;
                gnt_c[cand] = 1'b1;
                gnt_idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/tlm_frame_arbiter.sv
// Shares one telemetry RAM write port between NUM_SRC packet receivers,
// ping-ponging each source's frame between two banks.
module tlm_frame_arbiter
    import tlm_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned SRC_W   = src_idx_w(NUM_SRC)
) (
    input logic     clk,
    input logic     reset,
    tlm_arb_if.slave bus
);

    localparam int unsigned RAM_AW = SRC_W + 1 + TLM_ADDR_W;

    logic [NUM_SRC-1:0]    pend_vec;
    logic [NUM_SRC-1:0]    bank_vec;
    tlm_wr_t [NUM_SRC-1:0] pend_wr_vec;
    logic [NUM_SRC-1:0]    ready_vec;
    logic [NUM_SRC-1:0]    rbank_vec;
    logic [NUM_SRC-1:0]    ovf_vec;
    logic [NUM_SRC-1:0]    ovr_vec;

    logic [NUM_SRC-1:0]    gnt;
    logic [SRC_W-1:0]      gnt_idx;
    logic                  gnt_vld;
    logic [SRC_W-1:0]      ptr;

    logic                  ram_we_q;
    logic [RAM_AW-1:0]     ram_waddr_q;
    logic [TLM_DATA_W-1:0] ram_wdata_q;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_arb (
        .req       (pend_vec),
        .ptr       (ptr),
        .gnt_c     (gnt),
        .gnt_idx_c (gnt_idx),
        .gnt_vld_c (gnt_vld)
    );

    // Round-robin pointer and registered RAM write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= SRC_W'(NUM_SRC - 1);
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_we_q <= gnt_vld;
            if (gnt_vld) begin
                ptr         <= gnt_idx;
                ram_waddr_q <= {gnt_idx, bank_vec[gnt_idx], pend_wr_vec[gnt_idx].addr};
                ram_wdata_q <= pend_wr_vec[gnt_idx].data;
            end
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic    wclk_s;
        logic    wclk_q;
        tlm_wr_t cap_wr;
        logic    pend;
        tlm_wr_t pend_wr;
        logic    bank;
        logic    rdy;
        logic    rdy_bank;
        logic    ovf;
        logic    ovr;

        logic    rise;
        logic    drop;
        logic    complete;
        logic    rdy_after_ack;

        assign rise          = wclk_s & ~wclk_q;
        // A rise on the source being granted this cycle refills pending cleanly.
        assign drop          = rise & pend & ~gnt[i];
        assign complete      = gnt[i] & (pend_wr.addr == TLM_ADDR_W'(LAST_PARAM_ADDR));
        assign rdy_after_ack = rdy & ~bus.frame_ack[i];

        // Addr/byte are registered with the strobe so a one-cycle strobe latches
        // the values present when it was first sampled.
        always_ff @(posedge clk) begin
            if (reset) begin
                wclk_s   <= 1'b0;
                wclk_q   <= 1'b0;
                cap_wr   <= '0;
                pend     <= 1'b0;
                pend_wr  <= '0;
                bank     <= BANK_0;
                rdy      <= 1'b0;
                rdy_bank <= BANK_0;
                ovf      <= 1'b0;
                ovr      <= 1'b0;
            end else begin
                wclk_s      <= bus.src_wclk[i];
                wclk_q      <= wclk_s;
                cap_wr.addr <= bus.src_waddr[i*TLM_ADDR_W +: TLM_ADDR_W];
                cap_wr.data <= bus.src_byte[i*TLM_DATA_W +: TLM_DATA_W];

                if (rise && !drop) begin
                    pend    <= 1'b1;
                    pend_wr <= cap_wr;
                end else if (gnt[i]) begin
                    pend <= 1'b0;
                end

                // Ack is applied before completion; an unacked frame blocks the swap.
                if (complete && !rdy_after_ack) begin
                    rdy      <= 1'b1;
                    rdy_bank <= bank;
                    bank     <= (bank == BANK_0) ? BANK_1 : BANK_0;
                end else begin
                    rdy <= rdy_after_ack;
                end

                ovf <= (ovf & ~bus.err_clr) | drop;
                ovr <= (ovr & ~bus.err_clr) | (complete & rdy_after_ack);
            end
        end

        assign pend_vec[i]    = pend;
        assign pend_wr_vec[i] = pend_wr;
        assign bank_vec[i]    = bank;
        assign ready_vec[i]   = rdy;
        assign rbank_vec[i]   = rdy_bank;
        assign ovf_vec[i]     = ovf;
        assign ovr_vec[i]     = ovr;
    end

    assign bus.ram_we      = ram_we_q;
    assign bus.ram_waddr   = ram_waddr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.frame_ready = ready_vec;
    assign bus.ready_bank  = rbank_vec;
    assign bus.ovf_err     = ovf_vec;
    assign bus.overrun_err = ovr_vec;

endmodule

// File: tb/tb_tlm_frame_arbiter.sv
// Directed bench for tlm_frame_arbiter with three sources: arbitration order,
// latency, frame ping-pong, overrun/overflow flags and mid-frame reset.
module tb_tlm_frame_arbiter;
    import tlm_arb_pkg::*;

    localparam int unsigned NSRC = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tlm_arb_if #(.NUM_SRC(NSRC)) bus ();

    tlm_frame_arbiter #(.NUM_SRC(NSRC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected RAM address {src[1:0], bank, addr[4:0]}.
    function automatic logic [31:0] wa(input int unsigned src, input logic bank, input logic [4:0] addr);
        return 32'((src << 6) | (32'(bank) << 5) | 32'(addr));
    endfunction

    task automatic drive(input int unsigned src, input logic s, input logic [4:0] a, input logic [7:0] d);
        bus.src_wclk[src]        = s;
        bus.src_waddr[src*5 +: 5] = a;
        bus.src_byte[src*8 +: 8]  = d;
    endtask

    task automatic src_write(input int unsigned src, input logic [4:0] a, input logic [7:0] d,
                             input logic bank, input logic ack, input string tag);
        drive(src, 1'b1, a, d);
        tick();
        bus.src_wclk[src] = 1'b0;
        tick();
        if (ack) bus.frame_ack[src] = 1'b1;
        tick();
        bus.frame_ack[src] = 1'b0;
        check({tag, "_we"},    32'(bus.ram_we), 32'd1);
        check({tag, "_waddr"}, 32'(bus.ram_waddr), wa(src, bank, a));
        check({tag, "_wdata"}, 32'(bus.ram_wdata), 32'(d));
    endtask

    task automatic run_frame(input logic bank, input int unsigned seed, input logic ack_last,
                             input logic rdy_before, input string tag);
        for (int a = 0; a < 32; a++) begin
            src_write(0, 5'(a), 8'(a * 7 + int'(seed)), bank, ack_last && (a == 31), tag);
            if (a == 30) check({tag, "_rdy_at30"}, 32'(bus.frame_ready[0]), 32'(rdy_before));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_we"},      32'(bus.ram_we), 32'd0);
        check({tag, "_waddr"},   32'(bus.ram_waddr), 32'd0);
        check({tag, "_wdata"},   32'(bus.ram_wdata), 32'd0);
        check({tag, "_ready"},   32'(bus.frame_ready), 32'd0);
        check({tag, "_rbank"},   32'(bus.ready_bank), 32'd0);
        check({tag, "_ovf"},     32'(bus.ovf_err), 32'd0);
        check({tag, "_overrun"}, 32'(bus.overrun_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        reset         = 1'b1;
        bus.src_wclk  = '0;
        bus.src_waddr = '0;
        bus.src_byte  = '0;
        bus.frame_ack = '0;
        bus.err_clr   = 1'b0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();

        // Simultaneous rise after reset: source 0 has first priority.
        drive(0, 1'b1, 5'd4, 8'h11);
        drive(1, 1'b1, 5'd5, 8'h22);
        tick();
        bus.src_wclk = '0;
        tick();
        tick();
        check("pairA_first_addr", 32'(bus.ram_waddr), wa(0, 1'b0, 5'd4));
        check("pairA_first_data", 32'(bus.ram_wdata), 32'h11);
        tick();
        check("pairA_second_we",   32'(bus.ram_we), 32'd1);
        check("pairA_second_addr", 32'(bus.ram_waddr), wa(1, 1'b0, 5'd5));
        check("pairA_second_data", 32'(bus.ram_wdata), 32'h22);
        tick();
        check("pairA_done_we", 32'(bus.ram_we), 32'd0);

        // Single write: ram_we two edges after the strobe is first sampled, one cycle wide.
        drive(0, 1'b1, 5'd3, 8'hA5);
        tick();
        bus.src_wclk[0] = 1'b0;
        tick();
        check("single_early_we", 32'(bus.ram_we), 32'd0);
        tick();
        check("single_we",    32'(bus.ram_we), 32'd1);
        check("single_waddr", 32'(bus.ram_waddr), 32'h03);
        check("single_wdata", 32'(bus.ram_wdata), 32'hA5);
        tick();
        check("single_pulse_end", 32'(bus.ram_we), 32'd0);

        // Source 0 was granted last, so source 1 now wins the tie.
        drive(0, 1'b1, 5'd6, 8'h33);
        drive(1, 1'b1, 5'd7, 8'h44);
        tick();
        bus.src_wclk = '0;
        tick();
        tick();
        check("pairB_first_addr", 32'(bus.ram_waddr), wa(1, 1'b0, 5'd7));
        check("pairB_first_data", 32'(bus.ram_wdata), 32'h44);
        tick();
        check("pairB_second_addr", 32'(bus.ram_waddr), wa(0, 1'b0, 5'd6));
        check("pairB_second_data", 32'(bus.ram_wdata), 32'h33);
        tick();

        // Source 0 held off by 1 and 2 while it strobes a second time.
        drive(0, 1'b1, 5'd8, 8'h55);
        drive(1, 1'b1, 5'd9, 8'h66);
        drive(2, 1'b1, 5'd10, 8'h88);
        tick();
        bus.src_wclk = '0;
        tick();
        drive(0, 1'b1, 5'd11, 8'h77);
        tick();
        bus.src_wclk[0] = 1'b0;
        check("ovf_w1_addr", 32'(bus.ram_waddr), wa(1, 1'b0, 5'd9));
        check("ovf_w1_data", 32'(bus.ram_wdata), 32'h66);
        tick();
        check("ovf_w2_addr", 32'(bus.ram_waddr), wa(2, 1'b0, 5'd10));
        check("ovf_w2_data", 32'(bus.ram_wdata), 32'h88);
        check("ovf_flag",    32'(bus.ovf_err), 32'b001);
        tick();
        check("ovf_kept_we",   32'(bus.ram_we), 32'd1);
        check("ovf_kept_addr", 32'(bus.ram_waddr), wa(0, 1'b0, 5'd8));
        check("ovf_kept_data", 32'(bus.ram_wdata), 32'h55);
        tick();
        check("ovf_dropped_we", 32'(bus.ram_we), 32'd0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("ovf_cleared", 32'(bus.ovf_err), 32'd0);

        // Frame 1 into bank 0.
        run_frame(1'b0, 1, 1'b0, 1'b0, "f1");
        check("f1_ready",   32'(bus.frame_ready), 32'b001);
        check("f1_rbank",   32'(bus.ready_bank), 32'b000);
        check("f1_overrun", 32'(bus.overrun_err), 32'd0);

        // Frame 2 into bank 1 without ack: dropped, reader's frame untouched.
        run_frame(1'b1, 2, 1'b0, 1'b1, "f2");
        check("f2_overrun", 32'(bus.overrun_err), 32'b001);
        check("f2_ready",   32'(bus.frame_ready), 32'b001);
        check("f2_rbank",   32'(bus.ready_bank), 32'b000);

        bus.frame_ack[0] = 1'b1;
        tick();
        bus.frame_ack[0] = 1'b0;
        check("ack_ready", 32'(bus.frame_ready), 32'd0);

        // Frame 3 still targets bank 1.
        run_frame(1'b1, 3, 1'b0, 1'b0, "f3");
        check("f3_ready",   32'(bus.frame_ready), 32'b001);
        check("f3_rbank",   32'(bus.ready_bank), 32'b001);
        check("f3_overrun", 32'(bus.overrun_err), 32'b001);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("errclr_overrun", 32'(bus.overrun_err), 32'd0);

        // Frame 4 into bank 0 with the ack landing on the completing grant.
        run_frame(1'b0, 4, 1'b1, 1'b1, "f4");
        check("f4_ready",   32'(bus.frame_ready), 32'b001);
        check("f4_rbank",   32'(bus.ready_bank), 32'b000);
        check("f4_overrun", 32'(bus.overrun_err), 32'd0);

        // Partial frame in bank 1, reset while addr 17 is pending.
        for (int a = 0; a < 17; a++)
            src_write(0, 5'(a), 8'(a + 8'h40), 1'b1, 1'b0, "part");
        drive(0, 1'b1, 5'd17, 8'hEE);
        tick();
        bus.src_wclk[0] = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_idle("midreset");
        reset = 1'b0;
        tick();
        tick();
        check("midreset_pending_dropped", 32'(bus.ram_we), 32'd0);

        // After reset the next frame restarts in bank 0.
        run_frame(1'b0, 5, 1'b0, 1'b0, "f5");
        check("f5_ready", 32'(bus.frame_ready), 32'b001);
        check("f5_rbank", 32'(bus.ready_bank), 32'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
